fb_pixel_writer: RTL and testbench

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_addr_map.sv | 16 +
 rtl/fb_pixel_writer.sv | 135 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer geometry shared by the pixel writer and the display read stage,
// plus the writer FSM state encoding.
package fb_pkg;

  localparam int FB_W             = 128;
  localparam int FB_H             = 128;
  localparam int FB_BYTES_PER_ROW = 16;
  localparam int FB_BYTES         = 2048;
  localparam int FB_ADDR_W        = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_CLR  = 3'd4
  } fb_state_e;

  // Clear value expands to a whole byte of lit or dark pixels.
  function automatic logic [7:0] fill_byte(input logic fill);
    return fill ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/fb_addr_map.sv
// Pixel coordinate to frame-RAM byte address / bit index mapping.
// Eight pixels per byte, bit 0 is the leftmost pixel, 16 bytes per row.
module fb_addr_map
  import fb_pkg::*;
(
  input  logic [6:0]           x,
  input  logic [6:0]           y,
  output logic [FB_ADDR_W-1:0] addr,
  output logic [2:0]           bit_idx
);

  // addr = y*16 + x/8 is a plain concatenation because the row is 16 bytes.
  assign addr    = {y, x[6:3]};
  assign bit_idx = x[2:0];

endmodule

// File: rtl/fb_pixel_writer.sv
// Single-pixel read-modify-write and full-screen clear into a 1bpp frame RAM
// over a registered port B (one-cycle read latency).
//
// Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready.
// pix_ready is high only in IDLE with no clear being requested that cycle, so
// a clear always wins over a simultaneous pixel. Nothing is queued while busy.
module fb_pixel_writer
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [6:0]           pix_x,
  input  logic [6:0]           pix_y,
  input  logic                 pix_on,
  input  logic                 clr_req,
  input  logic                 clr_fill,
  output logic                 busy,
  output logic                 clr_done,
  output logic [FB_ADDR_W-1:0] b_addr,
  output logic [7:0]           b_wdata,
  output logic                 b_we,
  input  logic [7:0]           b_rdata,
  output fb_state_e            dbg_state
);

  fb_state_e            state_q, state_d;
  logic [6:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic                 on_q, on_d;
  logic [FB_ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [7:0]           b_wdata_q, b_wdata_d;
  logic                 b_we_q, b_we_d;
  logic                 clr_done_q, clr_done_d;

  logic [6:0]           map_x, map_y;
  logic [FB_ADDR_W-1:0] map_addr;
  logic [2:0]           map_bit;

  // In IDLE the mapper sees the incoming pixel (to issue the read address);
  // afterwards it sees the latched pixel (to pick the bit to replace).
  always_comb begin
    map_x = (state_q == ST_IDLE) ? pix_x : x_q;
    map_y = (state_q == ST_IDLE) ? pix_y : y_q;
  end

  fb_addr_map u_map (
    .x       (map_x),
    .y       (map_y),
    .addr    (map_addr),
    .bit_idx (map_bit)
  );

  // Next-state and registered-output logic for the writer FSM.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    on_d       = on_q;
    b_addr_d   = b_addr_q;
    b_wdata_d  = b_wdata_q;
    b_we_d     = 1'b0;
    clr_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          b_addr_d  = '0;
          b_wdata_d = fill_byte(clr_fill);
          b_we_d    = 1'b1;
          state_d   = ST_CLR;
        end else if (pix_valid) begin
          x_d      = pix_x;
          y_d      = pix_y;
          on_d     = pix_on;
          b_addr_d = map_addr;
          state_d  = ST_RD;
        end
      end
      // Address was presented at the edge entering RD; data appears in CAP.
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        b_wdata_d          = b_rdata;
        b_wdata_d[map_bit] = on_q;
        b_we_d             = 1'b1;
        state_d            = ST_WR;
      end
      // The RAM commits at the edge leaving WR, so a following pixel's read
      // always sees this write without any forwarding.
      ST_WR: state_d = ST_IDLE;
      ST_CLR: begin
        if (b_addr_q == FB_ADDR_W'(FB_BYTES - 1)) begin
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          b_addr_d = b_addr_q + 1'b1;
          b_we_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      on_q       <= 1'b0;
      b_addr_q   <= '0;
      b_wdata_q  <= '0;
      b_we_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      on_q       <= on_d;
      b_addr_q   <= b_addr_d;
      b_wdata_q  <= b_wdata_d;
      b_we_q     <= b_we_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign pix_ready = (state_q == ST_IDLE) && !clr_req;
  assign busy      = (state_q != ST_IDLE);
  assign clr_done  = clr_done_q;
  assign b_addr    = b_addr_q;
  assign b_wdata   = b_wdata_q;
  assign b_we      = b_we_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a behavioural frame RAM on port B.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [6:0]  pix_x = '0;
  logic [6:0]  pix_y = '0;
  logic        pix_on = 1'b0;
  logic        clr_req = 1'b0;
  logic        clr_fill = 1'b0;
  logic        busy;
  logic        clr_done;
  logic [10:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_we;
  logic [7:0]  b_rdata;
  fb_state_e   dbg_state;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  fb_pixel_writer dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on), .clr_req(clr_req),
    .clr_fill(clr_fill), .busy(busy), .clr_done(clr_done), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_we(b_we), .b_rdata(b_rdata), .dbg_state(dbg_state)
  );

  // ---------------- frame RAM model (read-before-write, 1-cycle latency) ----
  logic [7:0] ram [0:2047];
  logic       preload_req = 1'b0;
  logic [7:0] preload_val = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload_req) begin
      for (int i = 0; i < 2048; i++) ram[i] <= preload_val;
    end else if (b_we) begin
      ram[b_addr] <= b_wdata;
    end
    b_rdata <= ram[b_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] v);
    @(negedge clk);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_pixel(input logic [6:0] x, input logic [6:0] y,
                            input logic on, output int acc);
    int n;
    pix_x = x; pix_y = y; pix_on = on; pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) $display("FAIL accept_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, n);
    else passed++;
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (busy) $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_IDLE); else passed++;
    checks++; if (b_addr !== 11'd0) $display("FAIL rst_b_addr: got %0d, required 0", b_addr); else passed++;
    checks++; if (b_wdata !== 8'h00) $display("FAIL rst_b_wdata: got %02h, required 00", b_wdata); else passed++;
    checks++; if (b_we !== 1'b0) $display("FAIL rst_b_we: got %0b, required 0", b_we); else passed++;
    checks++; if (clr_done !== 1'b0) $display("FAIL rst_clr_done: got %0b, required 0", clr_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b, required 0", busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b1) $display("FAIL rst_pix_ready: got %0b, required 1", pix_ready); else passed++;
  endtask

  task automatic test_single_write();
    int acc, low, we_cnt;
    logic [7:0] wd;
    preload(8'h00);
    send_pixel(7'd10, 7'd3, 1'b1, acc);
    checks++; if (dbg_state !== ST_RD) $display("FAIL single_state_rd: got %0d, required %0d", dbg_state, ST_RD); else passed++;
    checks++; if (b_addr !== 11'd49) $display("FAIL single_addr: got %0d, required 49", b_addr); else passed++;
    low = 0; we_cnt = 0; wd = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (pix_ready) break;
      low++;
      if (b_we) begin we_cnt++; wd = b_wdata; end
      @(negedge clk);
    end
    // Accept cycle plus RD, CAP, WR gives four-cycle accept-to-accept spacing.
    checks++; if (low !== 3) $display("FAIL single_ready_low: got %0d cycles after accept, required 3", low); else passed++;
    checks++; if (we_cnt !== 1) $display("FAIL single_we_cycles: got %0d, required 1", we_cnt); else passed++;
    checks++; if (wd !== 8'h04) $display("FAIL single_wdata: got %02h, required 04", wd); else passed++;
    checks++; if (ram[49] !== 8'h04) $display("FAIL single_ram49: got %02h, required 04", ram[49]); else passed++;
    checks++; if (ram[48] !== 8'h00 || ram[50] !== 8'h00) $display("FAIL single_neighbours: got %02h/%02h, required 00/00", ram[48], ram[50]); else passed++;
  endtask

  task automatic test_corner_write();
    int acc;
    preload(8'hFF);
    send_pixel(7'd127, 7'd127, 1'b0, acc);
    checks++; if (b_addr !== 11'd2047) $display("FAIL corner_addr: got %0d, required 2047", b_addr); else passed++;
    wait_idle("corner", 10);
    checks++; if (ram[2047] !== 8'h7F) $display("FAIL corner_ram2047: got %02h, required 7F", ram[2047]); else passed++;
    checks++; if (ram[2046] !== 8'hFF) $display("FAIL corner_ram2046: got %02h, required FF", ram[2046]); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc0, acc1;
    preload(8'h00);
    send_pixel(7'd0, 7'd0, 1'b1, acc0);
    send_pixel(7'd1, 7'd0, 1'b1, acc1);
    checks++; if (acc1 - acc0 !== 4) $display("FAIL b2b_spacing: got %0d cycles, required 4", acc1 - acc0); else passed++;
    wait_idle("b2b", 10);
    checks++; if (ram[0] !== 8'h03) $display("FAIL b2b_ram0: got %02h, required 03", ram[0]); else passed++;
  endtask

  task automatic test_clear();
    int wr, bad, done_cnt, busy_gap, late_we, ff_cnt;
    logic [10:0] exp_addr;
    preload(8'h00);
    clr_fill = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0; clr_fill = 1'b0;
    pix_x = 7'd9; pix_y = 7'd9; pix_on = 1'b0; pix_valid = 1'b1;
    wr = 0; bad = 0; done_cnt = 0; busy_gap = 0; exp_addr = '0;
    for (int i = 0; i < 2060; i++) begin
      if (i == 500) clr_req = 1'b1;
      if (i == 501) clr_req = 1'b0;
      if (i == 1000) pix_valid = 1'b0;
      if (b_we) begin
        if (b_addr !== exp_addr || b_wdata !== 8'hFF) bad++;
        exp_addr++; wr++;
      end
      if (clr_done) begin
        done_cnt++;
        if (b_we) bad++;
      end
      if (wr < 2048 && !busy) busy_gap++;
      @(negedge clk);
    end
    late_we = 0;
    for (int i = 0; i < 8; i++) begin if (b_we || busy) late_we++; @(negedge clk); end
    ff_cnt = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] === 8'hFF) ff_cnt++;
    checks++; if (wr !== 2048) $display("FAIL clr_writes: got %0d, required 2048", wr); else passed++;
    checks++; if (bad !== 0) $display("FAIL clr_sequence: got %0d bad cycles, required 0", bad); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL clr_done_pulses: got %0d, required 1", done_cnt); else passed++;
    checks++; if (busy_gap !== 0) $display("FAIL clr_busy: got %0d low cycles during clear, required 0", busy_gap); else passed++;
    checks++; if (late_we !== 0) $display("FAIL clr_ignored_reqs: got %0d active cycles after clear, required 0", late_we); else passed++;
    checks++; if (ff_cnt !== 2048) $display("FAIL clr_ram: got %0d bytes FF, required 2048", ff_cnt); else passed++;
  endtask

  task automatic test_clr_wins();
    int n;
    preload(8'h00);
    clr_fill = 1'b1; clr_req = 1'b1;
    pix_x = 7'd5; pix_y = 7'd0; pix_on = 1'b0; pix_valid = 1'b1;
    #1;
    checks++; if (pix_ready !== 1'b0) $display("FAIL clrwin_ready: got %0b, required 0", pix_ready); else passed++;
    @(negedge clk);
    clr_req = 1'b0; clr_fill = 1'b0;
    checks++; if (dbg_state !== ST_CLR) $display("FAIL clrwin_state: got %0d, required %0d", dbg_state, ST_CLR); else passed++;
    n = 0;
    while (!clr_done && n < 2100) begin @(negedge clk); n++; end
    checks++; if (!clr_done) $display("FAIL clrwin_done_timeout: clr_done=%0b after %0d cycles, required 1", clr_done, n); else passed++;
    checks++; if (pix_ready !== 1'b1) $display("FAIL clrwin_ready_after: got %0b, required 1", pix_ready); else passed++;
    @(negedge clk);
    pix_valid = 1'b0;
    checks++; if (dbg_state !== ST_RD) $display("FAIL clrwin_pix_accept: got %0d, required %0d", dbg_state, ST_RD); else passed++;
    wait_idle("clrwin", 10);
    checks++; if (ram[0] !== 8'hDF) $display("FAIL clrwin_ram0: got %02h, required DF", ram[0]); else passed++;
    checks++; if (ram[1] !== 8'hFF) $display("FAIL clrwin_ram1: got %02h, required FF", ram[1]); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int n, done_cnt, we_cnt, ok_lo, ok_hi;
    preload(8'h00);
    clr_fill = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0; clr_fill = 1'b0;
    n = 0;
    while (!(b_we && b_addr == 11'd99) && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) $display("FAIL rstclr_reach99: not reached in %0d cycles, required addr 99", n); else passed++;
    // The write of address 99 lands at the reset edge: 100 bytes cleared.
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b_we !== 1'b0) $display("FAIL rstclr_we: got %0b, required 0", b_we); else passed++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL rstclr_state: got %0d, required %0d", dbg_state, ST_IDLE); else passed++;
    rst = 1'b0;
    done_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clr_done) done_cnt++;
      if (b_we) we_cnt++;
    end
    checks++; if (done_cnt !== 0) $display("FAIL rstclr_done: got %0d pulses, required 0", done_cnt); else passed++;
    checks++; if (we_cnt !== 0) $display("FAIL rstclr_writes: got %0d, required 0", we_cnt); else passed++;
    checks++; if (pix_ready !== 1'b1) $display("FAIL rstclr_ready: got %0b, required 1", pix_ready); else passed++;
    ok_lo = 0; ok_hi = 0;
    for (int i = 0; i < 100; i++) if (ram[i] === 8'hFF) ok_lo++;
    for (int i = 100; i < 2048; i++) if (ram[i] === 8'h00) ok_hi++;
    checks++; if (ok_lo !== 100) $display("FAIL rstclr_low_bytes: got %0d cleared, required 100", ok_lo); else passed++;
    checks++; if (ok_hi !== 1948) $display("FAIL rstclr_high_bytes: got %0d untouched, required 1948", ok_hi); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_corner_write();
    test_back_to_back();
    test_clear();
    test_clr_wins();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
